// File: rtl/mem_dump_ctrl.sv
// Debug memory-dump sequencer: freezes the pipeline, walks every data-memory word
// through the debug read port and streams each word little-endian to the UART TX.
module mem_dump_ctrl #(
    parameter int NUM_WORDS = 32,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        stall_o,
    output logic        debug_on_o,
    output logic [31:0] debug_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  dbg_state_o
);

    localparam int ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [2:0] LAT_MAX = 3'(READ_LAT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [2:0]        latCnt, latCntNext;
    logic [1:0]        byteIdx, byteIdxNext;
    logic [31:0]       word, wordNext;
    logic              xfer;

    // Handshake: a byte moves on a rising edge where tx_valid_o and tx_ready_i are both
    // high; while ready is low, tx_valid_o stays high and tx_data_o holds its value.
    assign xfer = (state == SEND) && tx_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            latCnt  <= '0;
            byteIdx <= '0;
            word    <= '0;
        end else begin
            state   <= stateNext;
            addr    <= addrNext;
            latCnt  <= latCntNext;
            byteIdx <= byteIdxNext;
            word    <= wordNext;
        end
    end

    always_comb begin
        stateNext   = state;
        addrNext    = addr;
        latCntNext  = latCnt;
        byteIdxNext = byteIdx;
        wordNext    = word;
        case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    stateNext  = WAIT;
                    addrNext   = '0;
                    latCntNext = '0;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    stateNext = IDLE;
                end else if (latCnt == LAT_MAX) begin
                    stateNext = CAPT;
                end else begin
                    latCntNext = latCnt + 3'd1;
                end
            end
            CAPT: begin
                if (abort_i) begin
                    stateNext = IDLE;
                end else begin
                    wordNext    = mem_data_i;
                    byteIdxNext = '0;
                    stateNext   = SEND;
                end
            end
            SEND: begin
                // An abort still lets the byte on the wire this cycle complete.
                if (abort_i) begin
                    stateNext = IDLE;
                end else if (xfer) begin
                    if (byteIdx != 2'd3) begin
                        byteIdxNext = byteIdx + 2'd1;
                    end else if (addr == LAST_ADDR) begin
                        stateNext = DONE;
                    end else begin
                        addrNext   = addr + ADDR_W'(1);
                        latCntNext = '0;
                        stateNext  = WAIT;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs decode from state and registers only, so no input reaches an output.
    assign stall_o      = (state != IDLE);
    assign busy_o       = (state != IDLE);
    assign debug_on_o   = (state == WAIT) || (state == CAPT) || (state == SEND);
    assign debug_addr_o = debug_on_o ? 32'(addr) : 32'd0;
    assign tx_valid_o   = (state == SEND);
    assign tx_data_o    = (state == SEND) ? word[{byteIdx, 3'b000} +: 8] : 8'd0;
    assign done_o       = (state == DONE);
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: three instances (different NUM_WORDS/READ_LAT) fed by a
// latency-accurate memory model; expected bytes are queued at start and popped per transfer.
module tb_mem_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        startS[3], abortS[3], txReady[3];
  logic        stall[3], debugOn[3], txValid[3], busy[3], done[3];
  logic [31:0] dbgAddr[3], memData[3];
  logic [7:0]  txData[3];
  logic [2:0]  dbgState[3];

  logic [31:0] mem[3][4];
  logic [31:0] rd0, lat3a, lat3b, lat3c;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int sent, doneCnt, doneCyc, firstValid;

  mem_dump_ctrl #(.NUM_WORDS(4), .READ_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start_i(startS[0]), .abort_i(abortS[0]),
    .stall_o(stall[0]), .debug_on_o(debugOn[0]), .debug_addr_o(dbgAddr[0]),
    .mem_data_i(memData[0]), .tx_data_o(txData[0]), .tx_valid_o(txValid[0]),
    .tx_ready_i(txReady[0]), .busy_o(busy[0]), .done_o(done[0]), .dbg_state_o(dbgState[0])
  );

  mem_dump_ctrl #(.NUM_WORDS(2), .READ_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start_i(startS[1]), .abort_i(abortS[1]),
    .stall_o(stall[1]), .debug_on_o(debugOn[1]), .debug_addr_o(dbgAddr[1]),
    .mem_data_i(memData[1]), .tx_data_o(txData[1]), .tx_valid_o(txValid[1]),
    .tx_ready_i(txReady[1]), .busy_o(busy[1]), .done_o(done[1]), .dbg_state_o(dbgState[1])
  );

  mem_dump_ctrl #(.NUM_WORDS(3), .READ_LAT(3)) u2 (
    .clk(clk), .rst(rst), .start_i(startS[2]), .abort_i(abortS[2]),
    .stall_o(stall[2]), .debug_on_o(debugOn[2]), .debug_addr_o(dbgAddr[2]),
    .mem_data_i(memData[2]), .tx_data_o(txData[2]), .tx_valid_o(txValid[2]),
    .tx_ready_i(txReady[2]), .busy_o(busy[2]), .done_o(done[2]), .dbg_state_o(dbgState[2])
  );

  // Memory model: data appears READ_LAT cycles after the address.
  always_ff @(posedge clk) begin
    rd0   <= mem[0][dbgAddr[0][1:0]];
    lat3a <= mem[2][dbgAddr[2][1:0]];
    lat3b <= lat3a;
    lat3c <= lat3b;
  end

  always_comb begin
    memData[0] = rd0;
    memData[1] = mem[1][dbgAddr[1][1:0]];
    memData[2] = lat3c;
  end

  task automatic push_word(input int d, input int w, input int nbytes);
    logic [31:0] v;
    v = mem[d][w];
    for (int b = 0; b < nbytes; b++) exp_q.push_back(v[8*b +: 8]);
  endtask

  task automatic pulse_start(input int d);
    startS[d] = 1'b1;
    @(negedge clk);
    startS[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({stall[d], debugOn[d], txValid[d], busy[d], done[d]} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl d%0d got %b want 00000", d,
                 {stall[d], debugOn[d], txValid[d], busy[d], done[d]});
      end
      vectors++;
      if (dbgAddr[d] !== 32'd0 || txData[d] !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_data d%0d addr %h data %h want 0/0", d, dbgAddr[d], txData[d]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    mem[0][0] = 32'hDEADBEEF;
    txReady[0] = 1'b1;
    pulse_start(0);
    sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      if (txValid[0] && txReady[0]) sent++;
      @(negedge clk);
    end
    vectors++;
    if (sent !== 2 || txValid[0] !== 1'b1 || txData[0] !== 8'hAD) begin
      miscompares++;
      $display("FAIL reset_pre sent %0d valid %b data %h want 2/1/ad", sent, txValid[0], txData[0]);
    end
    txReady[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall[0], debugOn[0], txValid[0], busy[0], done[0]} !== 5'b0 || dbgState[0] !== 3'd0
        || txData[0] !== 8'd0 || dbgAddr[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid ctrl %b state %0d data %h addr %h want all 0",
               {stall[0], debugOn[0], txValid[0], busy[0], done[0]}, dbgState[0], txData[0], dbgAddr[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    pulse_start(0);
    for (int c = 0; c < 20 && !txValid[0]; c++) @(negedge clk);
    vectors++;
    if (txValid[0] !== 1'b1 || dbgAddr[0] !== 32'd0 || txData[0] !== 8'hEF) begin
      miscompares++;
      $display("FAIL reset_restart valid %b addr %h data %h want 1/0/ef", txValid[0], dbgAddr[0], txData[0]);
    end
    abortS[0] = 1'b1;
    @(negedge clk);
    abortS[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] e;
    mem[0][0] = 32'h11223344; mem[0][1] = 32'hA5A5A5A5;
    mem[0][2] = 32'h00000000; mem[0][3] = 32'hFFFFFFFF;
    txReady[0] = 1'b1;
    for (int w = 0; w < 4; w++) push_word(0, w, 4);
    pulse_start(0);
    sent = 0; doneCnt = 0; doneCyc = 0; firstValid = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) begin
        vectors++;
        if (stall[0] !== 1'b1 || debugOn[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_stall stall %b dbg_on %b want 1/1", stall[0], debugOn[0]);
        end
      end
      if (txValid[0] && firstValid == 0) firstValid = cyc;
      if (txValid[0] && txReady[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL basic_extra byte %h with empty queue", txData[0]);
        end else begin
          e = exp_q.pop_front();
          if (txData[0] !== e || dbgAddr[0] !== 32'(sent / 4)) begin
            miscompares++;
            $display("FAIL basic_byte %0d got %h@%0d want %h@%0d", sent, txData[0], dbgAddr[0], e, sent / 4);
          end
        end
        sent++;
      end
      if (done[0]) begin doneCnt++; doneCyc = cyc; end
      @(negedge clk);
    end
    vectors++;
    if (firstValid !== 4) begin
      miscompares++;
      $display("FAIL basic_first_valid got %0d want 4", firstValid);
    end
    vectors++;
    if (doneCnt !== 1 || doneCyc !== 29) begin
      miscompares++;
      $display("FAIL basic_done count %0d cycle %0d want 1/29", doneCnt, doneCyc);
    end
    vectors++;
    if (sent !== 16 || exp_q.size() !== 0 || stall[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end sent %0d left %0d stall %b want 16/0/0", sent, exp_q.size(), stall[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e, prevData;
    logic prevHold;
    for (int w = 0; w < 4; w++) mem[0][w] = $urandom;
    for (int w = 0; w < 4; w++) push_word(0, w, 4);
    txReady[0] = 1'b0;
    pulse_start(0);
    sent = 0; doneCnt = 0; prevHold = 1'b0; prevData = 8'd0;
    for (int cyc = 1; cyc <= 400 && doneCnt == 0; cyc++) begin
      txReady[0] = ($urandom_range(0, 99) < 30);
      if (prevHold && txValid[0]) begin
        vectors++;
        if (txData[0] !== prevData) begin
          miscompares++;
          $display("FAIL bp_hold cyc %0d got %h want %h", cyc, txData[0], prevData);
        end
      end
      if (txValid[0] && txReady[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra byte %h with empty queue", txData[0]);
        end else begin
          e = exp_q.pop_front();
          if (txData[0] !== e) begin
            miscompares++;
            $display("FAIL bp_byte %0d got %h want %h", sent, txData[0], e);
          end
        end
        sent++;
      end
      if (done[0]) doneCnt++;
      prevHold = txValid[0] && !txReady[0];
      prevData = txData[0];
      @(negedge clk);
    end
    txReady[0] = 1'b0;
    vectors++;
    if (doneCnt !== 1 || sent !== 16 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL bp_end done %0d sent %0d left %0d want 1/16/0", doneCnt, sent, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_read_lat();
    logic [7:0] e;
    int nw, rl;
    mem[1][0] = 32'h12345678; mem[1][1] = 32'hCAFEF00D;
    mem[2][0] = 32'h12345678; mem[2][1] = 32'h0BADF00D; mem[2][2] = 32'h80000001;
    for (int d = 1; d < 3; d++) begin
      nw = (d == 1) ? 2 : 3;
      rl = (d == 1) ? 0 : 3;
      for (int w = 0; w < nw; w++) push_word(d, w, 4);
      txReady[d] = 1'b1;
      pulse_start(d);
      sent = 0; doneCnt = 0; doneCyc = 0; firstValid = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        if (txValid[d] && firstValid == 0) firstValid = cyc;
        if (txValid[d] && txReady[d]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL lat%0d_extra byte %h with empty queue", rl, txData[d]);
          end else begin
            e = exp_q.pop_front();
            if (txData[d] !== e || dbgAddr[d] !== 32'(sent / 4)) begin
              miscompares++;
              $display("FAIL lat%0d_byte %0d got %h@%0d want %h@%0d", rl, sent, txData[d], dbgAddr[d], e, sent / 4);
            end
          end
          sent++;
        end
        if (done[d]) begin doneCnt++; doneCyc = cyc; end
        @(negedge clk);
      end
      vectors++;
      if (firstValid !== 3 + rl || doneCnt !== 1 || doneCyc !== nw * (rl + 6) + 1) begin
        miscompares++;
        $display("FAIL lat%0d_timing first %0d done %0d@%0d want %0d/1@%0d",
                 rl, firstValid, doneCnt, doneCyc, 3 + rl, nw * (rl + 6) + 1);
      end
      vectors++;
      if (sent !== 4 * nw || exp_q.size() !== 0) begin
        miscompares++;
        $display("FAIL lat%0d_count sent %0d left %0d want %0d/0", rl, sent, exp_q.size(), 4 * nw);
      end
      txReady[d] = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    logic checkNext;
    mem[0][0] = 32'h11223344; mem[0][1] = 32'hA5A5A5A5;
    mem[0][2] = 32'h01020304; mem[0][3] = 32'hFFFFFFFF;
    push_word(0, 0, 4); push_word(0, 1, 4); push_word(0, 2, 2);
    txReady[0] = 1'b1;
    pulse_start(0);
    sent = 0; doneCnt = 0; checkNext = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (checkNext) begin
        checkNext = 1'b0;
        vectors++;
        if (stall[0] !== 1'b0 || txValid[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_stall stall %b valid %b want 0/0", stall[0], txValid[0]);
        end
      end
      if (sent == 9 && txValid[0]) begin
        abortS[0] = 1'b1;
        checkNext = 1'b1;
      end
      if (txValid[0] && txReady[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL abort_extra byte %h after abort", txData[0]);
        end else begin
          e = exp_q.pop_front();
          if (txData[0] !== e) begin
            miscompares++;
            $display("FAIL abort_byte %0d got %h want %h", sent, txData[0], e);
          end
        end
        sent++;
      end
      if (done[0]) doneCnt++;
      @(negedge clk);
      abortS[0] = 1'b0;
    end
    vectors++;
    if (sent !== 10 || doneCnt !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL abort_end sent %0d done %0d left %0d want 10/0/0", sent, doneCnt, exp_q.size());
    end
  endtask

  task automatic test_ignored_ctrl();
    logic [7:0] e;
    for (int w = 0; w < 4; w++) push_word(0, w, 4);
    txReady[0] = 1'b1;
    pulse_start(0);
    sent = 0; doneCnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      startS[0] = (cyc == 10);
      if (txValid[0] && txReady[0]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ign_extra byte %h with empty queue", txData[0]);
        end else begin
          e = exp_q.pop_front();
          if (txData[0] !== e) begin
            miscompares++;
            $display("FAIL ign_byte %0d got %h want %h", sent, txData[0], e);
          end
        end
        sent++;
      end
      if (done[0]) doneCnt++;
      @(negedge clk);
    end
    startS[0] = 1'b0;
    vectors++;
    if (sent !== 16 || doneCnt !== 1) begin
      miscompares++;
      $display("FAIL ign_count sent %0d done %0d want 16/1", sent, doneCnt);
    end
    startS[0] = 1'b1;
    abortS[0] = 1'b1;
    @(negedge clk);
    startS[0] = 1'b0;
    abortS[0] = 1'b0;
    vectors++;
    if (stall[0] !== 1'b0 || dbgState[0] !== 3'd0) begin
      miscompares++;
      $display("FAIL ign_both stall %b state %0d want 0/0", stall[0], dbgState[0]);
    end
    @(negedge clk);
    vectors++;
    if (stall[0] !== 1'b0 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_both_late stall %b busy %b want 0/0", stall[0], busy[0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      startS[d] = 1'b0;
      abortS[d] = 1'b0;
      txReady[d] = 1'b0;
      for (int w = 0; w < 4; w++) mem[d][w] = 32'd0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_read_lat();
    test_abort();
    test_ignored_ctrl();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
